snn_online_trainer: RTL and testbench



---
 rtl/snn_train_pkg.sv | 30 +++
 rtl/snn_online_trainer_trace.sv | 19 +
 rtl/snn_online_trainer.sv | 154 +++++++++++++++
 tb/tb_snn_online_trainer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_train_pkg.sv
// Shared types and arithmetic for the tinySNN online trainer.
package snn_train_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        UPDATE   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // Threshold / membrane width: integer part, fractional bits, headroom.
    function automatic int calc_tw(input int pw, input int pres);
        return pw + pres + 6;
    endfunction

    // Weight EMA: (w*(2^sh-1) + snap) >> sh. Operands are zero-extended to
    // 64 bits; for the supported widths nothing overflows, so the result is
    // identical to the narrow P_W+P_SH computation.
    function automatic logic [63:0] ema_w(input logic [63:0] w, input logic [63:0] snap,
                                          input int sh);
        return ((w * ((64'd1 << sh) - 64'd1)) + snap) >> sh;
    endfunction

    // Threshold EMA toward the membrane value latched at the first spike.
    function automatic logic [63:0] ema_thr(input logic [63:0] thr, input logic [63:0] lv,
                                            input int sh);
        return ((thr * ((64'd1 << sh) - 64'd1)) + lv) >> sh;
    endfunction

endpackage

// File: rtl/snn_online_trainer_trace.sv
// Per-synapse presynaptic trace: loads all-ones on an event, otherwise
// decays by one per clock and saturates at zero.
module snn_trace #(
    parameter int P_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_evt,
    output logic [P_W-1:0] o_trace
);

    // Load-on-event saturating down counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)              o_trace <= '0;
        else if (i_evt)            o_trace <= '1;
        else if (o_trace != '0)    o_trace <= o_trace - P_W'(1);
    end

endmodule

// File: rtl/snn_online_trainer.sv
// Online STDP-style trainer for the tinySNN core: collects winners over a
// fixed window, then EMA-updates each winner's weights and threshold, one
// neuron per clock. Optional macro SNN_TRAIN_HOMEOSTASIS_EN lowers every
// threshold by P_DELTA_T when a window ends with no winner.
module snn_online_trainer
    import snn_train_pkg::*;
#(
    parameter int P_W       = 8,
    parameter int P_RES     = 8,
    parameter int P_N       = 8,
    parameter int P_S       = 42,
    parameter int P_SH      = 3,
    parameter int P_WAIT    = 10,
    parameter int P_DELTA_T = 'hFF,
    parameter int P_THR_DEF = 'h3F000,
    parameter int P_W_DEF   = 'hFF,
    parameter int P_WTA     = 0,
    localparam int TW       = calc_tw(P_W, P_RES)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_train_en,
    input  logic                     i_epoch_end,
    input  logic [P_S-1:0]           i_syn_evt,
    input  logic [P_N-1:0]           i_spike,
    input  logic [P_N*TW-1:0]        i_sv,
    output logic [P_N*P_S*P_W-1:0]   o_weights,
    output logic [P_N*TW-1:0]        o_thresholds,
    output logic                     o_busy,
    output logic                     o_update_done
);

    localparam int CW = $clog2(P_WAIT + 1);
    localparam int KW = (P_N > 1) ? $clog2(P_N) : 1;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q;
    logic [KW-1:0]                   k_q;
    logic [P_N-1:0]                  win_q, elig_mask;
    logic                            snap_vld_q, done_q;
    logic [P_S-1:0][P_W-1:0]         trace, snap_q, w_new;
    logic [P_N-1:0][TW-1:0]          lv_q, thr_q;
    logic [P_N-1:0][P_S-1:0][P_W-1:0] w_q;
    logic [TW-1:0]                   thr_new;
    logic                            abort, wait_done, last_k;

    // One trace counter per synapse.
    snn_trace #(.P_W(P_W)) u_trace [P_S-1:0] (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_evt   (i_syn_evt),
        .o_trace (trace)
    );

    assign abort     = i_epoch_end || !i_train_en;
    assign wait_done = (cnt_q == CW'(P_WAIT - 1));
    assign last_k    = (k_q == KW'(P_N - 1));

    // WTA keeps only the lowest-index winner (isolate lowest set bit).
    assign elig_mask = (P_WTA != 0) ? (win_q & (~win_q + P_N'(1))) : win_q;

    // All synapses of the selected neuron are updated in parallel.
    for (genvar s = 0; s < P_S; s++) begin : g_ema
        assign w_new[s] = P_W'(ema_w(64'(w_q[k_q][s]), 64'(snap_q[s]), P_SH));
    end
    assign thr_new = TW'(ema_thr(64'(thr_q[k_q]), 64'(lv_q[k_q]), P_SH));

`ifdef SNN_TRAIN_HOMEOSTASIS_EN
    logic [TW-1:0] thr_dec;
    assign thr_dec = (thr_q[k_q] > TW'(P_DELTA_T)) ? (thr_q[k_q] - TW'(P_DELTA_T)) : '0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; an abort only matters while collecting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_train_en && |i_syn_evt) state_d = COLLECT;
            COLLECT:  if (abort)          state_d = IDLE;
                      else if (wait_done) state_d = UPDATE;
            UPDATE:   if (last_k)         state_d = COOLDOWN;
            COOLDOWN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Window bookkeeping, snapshot/latch capture and the per-neuron update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            k_q        <= '0;
            win_q      <= '0;
            snap_vld_q <= 1'b0;
            snap_q     <= '0;
            lv_q       <= '0;
            done_q     <= 1'b0;
            w_q        <= {(P_N*P_S){P_W'(P_W_DEF)}};
            thr_q      <= {P_N{TW'(P_THR_DEF)}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    k_q   <= '0;
                end
                COLLECT: begin
                    cnt_q <= cnt_q + CW'(1);
                    win_q <= win_q | i_spike;
                    // Snapshot takes the pre-update trace of the first spike cycle.
                    if (!snap_vld_q && |i_spike) begin
                        snap_q     <= trace;
                        snap_vld_q <= 1'b1;
                    end
                    for (int n = 0; n < P_N; n++)
                        if (i_spike[n] && !win_q[n]) lv_q[n] <= i_sv[n*TW +: TW];
                    // Abort wins over any capture this cycle.
                    if (abort) begin
                        win_q      <= '0;
                        snap_vld_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    k_q <= k_q + KW'(1);
                    if (elig_mask[k_q]) begin
                        w_q[k_q]   <= w_new;
                        thr_q[k_q] <= thr_new;
                    end
`ifdef SNN_TRAIN_HOMEOSTASIS_EN
                    else if (win_q == '0) begin
                        thr_q[k_q] <= thr_dec;
                    end
`endif
                    done_q <= last_k;
                end
                COOLDOWN: begin
                    win_q      <= '0;
                    snap_vld_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_weights     = w_q;
    assign o_thresholds  = thr_q;
    assign o_busy        = (state_q != IDLE);
    assign o_update_done = done_q;

endmodule

// File: tb/tb_snn_online_trainer.sv
// Bench for snn_online_trainer: two instances (P_WTA=0 and P_WTA=1) share
// stimulus; a window-level reference model tracks expected weights,
// thresholds, busy and done. Directed table + corner sequences + random run.
module tb_snn_online_trainer;

    localparam int P_W = 8, P_RES = 8, P_N = 8, P_S = 42, P_SH = 3, P_WAIT = 10;
    localparam int TW = P_W + P_RES + 6;
    localparam longint THR_DEF = 'h3F000, DELTA = 'hFF;
    localparam int W_DEF = 'hFF;
    localparam int BUSY_LEN = P_WAIT + P_N + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic train_en = 1'b0, epoch_end = 1'b0;
    logic [P_S-1:0] evt = '0;
    logic [P_N-1:0] spike = '0;
    logic [P_N*TW-1:0] sv = '0;
    logic [P_N*P_S*P_W-1:0] w0, w1;
    logic [P_N*TW-1:0] t0, t1;
    logic busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    snn_online_trainer #(.P_WTA(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_train_en(train_en), .i_epoch_end(epoch_end),
        .i_syn_evt(evt), .i_spike(spike), .i_sv(sv), .o_weights(w0), .o_thresholds(t0),
        .o_busy(busy0), .o_update_done(done0));

    snn_online_trainer #(.P_WTA(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_train_en(train_en), .i_epoch_end(epoch_end),
        .i_syn_evt(evt), .i_spike(spike), .i_sv(sv), .o_weights(w1), .o_thresholds(t1),
        .o_busy(busy1), .o_update_done(done1));

    int checks = 0, errors = 0;
    int win_busy, win_done, win_done_at;

    // Reference model state (window position: -1 idle, 0..P_WAIT-1 collecting,
    // then P_N update slots, then one cooldown slot).
    int     mtr[P_S];
    int     msnap[P_S];
    bit     msnapv;
    logic [P_N-1:0] mmask;
    longint mlv[P_N];
    int     mpos;
    int     mw[2][P_N][P_S];
    longint mthr[2][P_N];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic longint gw(input int i, input int n, input int s);
        return (i == 0) ? longint'(w0[(n*P_S+s)*P_W +: P_W]) : longint'(w1[(n*P_S+s)*P_W +: P_W]);
    endfunction

    function automatic longint gt(input int i, input int n);
        return (i == 0) ? longint'(t0[n*TW +: TW]) : longint'(t1[n*TW +: TW]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < P_S; s++) begin mtr[s] = 0; msnap[s] = 0; end
        msnapv = 0; mmask = '0; mpos = -1;
        for (int n = 0; n < P_N; n++) begin
            mlv[n] = 0;
            for (int i = 0; i < 2; i++) begin
                mthr[i][n] = THR_DEF;
                for (int s = 0; s < P_S; s++) mw[i][n][s] = W_DEF;
            end
        end
    endtask

    // Whole-window learning step, applied at once when collection closes.
    task automatic apply_update();
        for (int i = 0; i < 2; i++) begin
            if (mmask == '0) begin
`ifdef SNN_TRAIN_HOMEOSTASIS_EN
                for (int n = 0; n < P_N; n++)
                    mthr[i][n] = (mthr[i][n] > DELTA) ? mthr[i][n] - DELTA : 0;
`endif
            end else begin
                for (int n = 0; n < P_N; n++) begin
                    bit el = mmask[n];
                    if (i == 1) for (int m = 0; m < n; m++) if (mmask[m]) el = 0;
                    if (el) begin
                        for (int s = 0; s < P_S; s++)
                            mw[i][n][s] = (mw[i][n][s] * ((1 << P_SH) - 1) + msnap[s]) >> P_SH;
                        mthr[i][n] = (mthr[i][n] * ((1 << P_SH) - 1) + mlv[n]) >> P_SH;
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        int tr_old[P_S];
        tr_old = mtr;
        if (mpos < 0) begin
            if (train_en && |evt) mpos = 0;
        end else if (mpos < P_WAIT) begin
            if (epoch_end || !train_en) begin
                mmask = '0; msnapv = 0; mpos = -1;
            end else begin
                for (int n = 0; n < P_N; n++)
                    if (spike[n] && !mmask[n]) mlv[n] = longint'(sv[n*TW +: TW]);
                if (!msnapv && |spike) begin msnap = tr_old; msnapv = 1; end
                mmask = mmask | spike;
                if (mpos == P_WAIT - 1) begin apply_update(); mpos = P_WAIT; end
                else mpos++;
            end
        end else if (mpos < P_WAIT + P_N) begin
            mpos++;
        end else begin
            mmask = '0; msnapv = 0; mpos = -1;
        end
        for (int s = 0; s < P_S; s++)
            mtr[s] = evt[s] ? (1 << P_W) - 1 : ((mtr[s] > 0) ? mtr[s] - 1 : 0);
    endtask

    task automatic check_state();
        for (int i = 0; i < 2; i++)
            for (int n = 0; n < P_N; n++) begin
                int bad = 0;
                for (int s = 0; s < P_S; s++) if (gw(i, n, s) != mw[i][n][s]) bad = s;
                if (gw(i, n, bad) != mw[i][n][bad])
                    chk($sformatf("w_i%0d_n%0d_s%0d", i, n, bad), gw(i, n, bad), mw[i][n][bad]);
                else chk("w", gw(i, n, bad), mw[i][n][bad]);
                if (gt(i, n) != mthr[i][n])
                    chk($sformatf("thr_i%0d_n%0d", i, n), gt(i, n), mthr[i][n]);
                else chk("thr", gt(i, n), mthr[i][n]);
            end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("busy0", busy0, mpos >= 0);
        chk("busy1", busy1, mpos >= 0);
        chk("done0", done0, mpos == P_WAIT + P_N);
        chk("done1", done1, mpos == P_WAIT + P_N);
        if (busy0) win_busy++;
        if (done0) begin win_done++; win_done_at = win_busy; end
        if (mpos < 0 || mpos == P_WAIT + P_N) check_state();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; evt = '0; spike = '0; sv = '0; epoch_end = 1'b0; train_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Event on synapse 0, spikes presented in the second collect cycle.
    task automatic run_window(input logic [P_N-1:0] sp, input logic [TW-1:0] svv);
        win_busy = 0; win_done = 0; win_done_at = 0;
        evt = P_S'(1); cyc();
        evt = '0;      cyc();
        spike = sp; sv = {P_N{svv}}; cyc();
        spike = '0;
        for (int i = 0; i < 60 && busy0; i++) cyc();
        if (busy0) chk("window_timeout", busy0, 0);
    endtask

    typedef struct {
        logic [P_N-1:0] sp;
        logic [TW-1:0]  svv;
        int             n;
        int             exp_w0;
        int             exp_w1;
        longint         exp_thr;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{sp: 8'h04, svv: 22'h0,      n: 2, exp_w0: 254, exp_w1: 223, exp_thr: 'h37200};
        tbl[1] = '{sp: 8'h02, svv: 22'h0,      n: 1, exp_w0: 254, exp_w1: 223, exp_thr: 'h37200};
        tbl[2] = '{sp: 8'h20, svv: 22'h3FFFFF, n: 5, exp_w0: 254, exp_w1: 223, exp_thr: 'hB71FF};
        tbl[3] = '{sp: 8'h80, svv: 22'h40000,  n: 7, exp_w0: 254, exp_w1: 223, exp_thr: 'h3F200};

        // Reset values, then 20 idle clocks.
        do_reset();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        train_en = 1'b1;
        repeat (20) cyc();
        for (int i = 0; i < 2; i++)
            for (int n = 0; n < P_N; n++) begin
                chk($sformatf("idle_thr_i%0d_n%0d", i, n), gt(i, n), THR_DEF);
                chk($sformatf("idle_w_i%0d_n%0d", i, n), gw(i, n, P_S - 1), W_DEF);
            end
        chk("idle_busy", busy0, 0);

        // Single-winner windows from the table.
        for (int t = 0; t < 4; t++) begin
            do_reset(); train_en = 1'b1;
            run_window(tbl[t].sp, tbl[t].svv);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("tbl%0d_i%0d_w0", t, i), gw(i, tbl[t].n, 0), tbl[t].exp_w0);
                chk($sformatf("tbl%0d_i%0d_w1", t, i), gw(i, tbl[t].n, 1), tbl[t].exp_w1);
                chk($sformatf("tbl%0d_i%0d_wlast", t, i), gw(i, tbl[t].n, P_S - 1), tbl[t].exp_w1);
                chk($sformatf("tbl%0d_i%0d_thr", t, i), gt(i, tbl[t].n), tbl[t].exp_thr);
                chk($sformatf("tbl%0d_i%0d_other", t, i), gt(i, (tbl[t].n + 1) % P_N), THR_DEF);
            end
            chk($sformatf("tbl%0d_busy_len", t), win_busy, BUSY_LEN);
            chk($sformatf("tbl%0d_done_cnt", t), win_done, 1);
            chk($sformatf("tbl%0d_done_at", t), win_done_at, BUSY_LEN);
        end

        // WTA: simultaneous spikes on neurons 3 and 5.
        do_reset(); train_en = 1'b1;
        run_window(8'h28, 22'h0);
        chk("wta0_thr3", gt(0, 3), 'h37200);
        chk("wta0_thr5", gt(0, 5), 'h37200);
        chk("wta1_thr3", gt(1, 3), 'h37200);
        chk("wta1_thr5", gt(1, 5), THR_DEF);
        chk("wta1_w5", gw(1, 5, 1), W_DEF);

        // Empty window.
        do_reset(); train_en = 1'b1;
        run_window('0, 22'h0);
        chk("empty_done", win_done, 1);
        for (int n = 0; n < P_N; n++)
`ifdef SNN_TRAIN_HOMEOSTASIS_EN
            chk($sformatf("empty_thr_n%0d", n), gt(0, n), 'h3EF01);
`else
            chk($sformatf("empty_thr_n%0d", n), gt(0, n), THR_DEF);
`endif

        // Drive neuron 0's threshold below P_DELTA_T, then an empty window.
        do_reset(); train_en = 1'b1;
        repeat (60) run_window(8'h01, 22'h0);
        chk("floor_pre_low", gt(0, 0) < DELTA, 1);
        run_window('0, 22'h0);
`ifdef SNN_TRAIN_HOMEOSTASIS_EN
        chk("floor_thr0", gt(0, 0), 0);
        chk("floor_thr1", gt(0, 1), 'h3EF01);
`else
        chk("floor_thr1", gt(0, 1), THR_DEF);
`endif

        // Epoch end in the fifth collect cycle aborts; a later window is fresh.
        do_reset(); train_en = 1'b1;
        win_busy = 0; win_done = 0;
        evt = P_S'(1); cyc();
        evt = '0; spike = 8'h10; cyc();
        spike = '0; repeat (3) cyc();
        epoch_end = 1'b1; cyc();
        epoch_end = 1'b0;
        chk("abort_busy", busy0, 0);
        repeat (25) cyc();
        chk("abort_no_done", win_done, 0);
        chk("abort_thr4", gt(0, 4), THR_DEF);
        chk("abort_w4", gw(0, 4, 0), W_DEF);
        run_window(8'h40, 22'h0);
        chk("fresh_thr4", gt(0, 4), THR_DEF);
        chk("fresh_thr6", gt(0, 6), 'h37200);
        chk("fresh_done", win_done, 1);

        // Asynchronous reset in the middle of UPDATE.
        do_reset(); train_en = 1'b1;
        evt = P_S'(1); cyc();
        evt = '0; spike = 8'h01; cyc();
        spike = '0;
        repeat (P_WAIT + 3) cyc();
        chk("mid_upd_changed", gt(0, 0), 'h37200);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_thr0", gt(0, 0), THR_DEF);
        chk("rst_mid_w0", gw(0, 0, 1), W_DEF);
        chk("rst_mid_busy", busy0, 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;

        // Randomised traffic against the model.
        train_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            evt = '0;
            if ($urandom_range(0, 5) == 0) evt[$urandom_range(0, P_S - 1)] = 1'b1;
            if ($urandom_range(0, 9) == 0) evt[$urandom_range(0, P_S - 1)] = 1'b1;
            spike = ($urandom_range(0, 4) == 0) ? P_N'($urandom) : '0;
            for (int n = 0; n < P_N; n++) sv[n*TW +: TW] = TW'($urandom);
            epoch_end = ($urandom_range(0, 79) == 0);
            train_en  = ($urandom_range(0, 149) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
